dds_wave_gen: RTL and testbench

Direct-digital-synthesis waveform generator that sits directly upstream of the DAC driver in the signal-generation path. It runs a 32-bit phase accumulator and addresses the external sine ROM. It selects sine, square, triangle or sawtooth, applies 8-bit amplitude scaling around midscale, and presents an 8-bit offset-binary `dac_value` for the DAC driver. Frequency, waveform and amplitude come from the key/menu control logic.

---
 rtl/dds_wave_gen.sv | 117 +++++++++++
 tb/tb_dds_wave_gen.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dds_wave_gen.sv
// DDS waveform generator: 32-bit phase accumulator feeding a three-stage
// pipeline (phase/ROM align, waveform select, amplitude scaling) to the DAC.
module dds_wave_gen #(
    parameter int PHASE_W = 32,
    parameter int ROM_AW  = 11
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PHASE_W-1:0] ftw,
    input  logic               ftw_load,
    input  logic               enable,
    input  logic               sync,
    input  logic [1:0]         wave_sel,
    input  logic [7:0]         amp,
    output logic [ROM_AW-1:0]  rom_addr,
    input  logic [7:0]         rom_q,
    output logic [7:0]         dac_value,
    output logic               dac_valid,
    output logic               phase_wrap
);
    localparam logic [1:0] WAVE_SINE   = 2'd0;
    localparam logic [1:0] WAVE_SQUARE = 2'd1;
    localparam logic [1:0] WAVE_TRI    = 2'd2;

    logic [PHASE_W-1:0] acc_reg;
    logic [PHASE_W-1:0] ftw_reg;
    logic [PHASE_W:0]   acc_sum;
    logic               wrap_reg;
    logic [7:0]         ph1_reg;
    logic [1:0]         sel1_reg;
    logic [7:0]         w2_reg;
    logic [7:0]         w2_next;
    logic [7:0]         dac_reg;
    logic [7:0]         dac_next;
    logic [2:0]         valid_sr_reg;
    logic signed [8:0]  centred;
    logic signed [16:0] product;
    logic signed [8:0]  shifted;

    // Carry-out of the add is the wrap indication.
    assign acc_sum = {1'b0, acc_reg} + {1'b0, ftw_reg};

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_reg  <= '0;
            ftw_reg  <= '0;
            wrap_reg <= 1'b0;
        end else begin
            if (ftw_load) begin
                ftw_reg <= ftw;
            end
            if (sync) begin
                acc_reg  <= '0;
                wrap_reg <= 1'b0;
            end else if (enable) begin
                acc_reg  <= acc_sum[PHASE_W-1:0];
                wrap_reg <= acc_sum[PHASE_W];
            end else begin
                wrap_reg <= 1'b0;
            end
        end
    end

    assign rom_addr = acc_reg[PHASE_W-1 -: ROM_AW];

    // Stage 1 lines up with the ROM's internal output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            ph1_reg  <= '0;
            sel1_reg <= '0;
        end else begin
            ph1_reg  <= acc_reg[PHASE_W-1 -: 8];
            sel1_reg <= wave_sel;
        end
    end

    always_comb begin
        w2_next = ph1_reg;
        case (sel1_reg)
            WAVE_SINE:   w2_next = rom_q;
            WAVE_SQUARE: w2_next = ph1_reg[7] ? 8'd0 : 8'd255;
            // 255 - p is ~p, so the falling half mirrors the rising half.
            WAVE_TRI:    w2_next = ph1_reg[7] ? {~ph1_reg[6:0], 1'b0}
                                              : {ph1_reg[6:0], 1'b0};
            default:     w2_next = ph1_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w2_reg <= 8'd128;
        end else begin
            w2_reg <= w2_next;
        end
    end

    // Scale around midscale; the floor shift keeps the result within 0..254.
    assign centred  = $signed({1'b0, w2_reg}) - 9'sd128;
    assign product  = centred * $signed({1'b0, amp});
    assign shifted  = 9'(product >>> 8);
    assign dac_next = 8'(shifted + 9'sd128);

    always_ff @(posedge clk) begin
        if (rst) begin
            dac_reg      <= 8'd128;
            valid_sr_reg <= '0;
        end else begin
            dac_reg      <= dac_next;
            valid_sr_reg <= {valid_sr_reg[1:0], 1'b1};
        end
    end

    assign dac_value  = dac_reg;
    assign dac_valid  = valid_sr_reg[2];
    assign phase_wrap = wrap_reg;

endmodule

// File: tb/tb_dds_wave_gen.sv
// Bench for dds_wave_gen: cycle model plus scoreboard queue, a table of
// single-phase vectors, and hand sequences for sync, load and mid-run reset.
module tb_dds_wave_gen;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ftw;
    logic        ftw_load;
    logic        enable;
    logic        sync;
    logic [1:0]  wave_sel;
    logic [7:0]  amp;
    logic [10:0] rom_addr;
    logic [7:0]  rom_q = 8'd0;
    logic [7:0]  dac_value;
    logic        dac_valid;
    logic        phase_wrap;

    dds_wave_gen #(.PHASE_W(32), .ROM_AW(11)) dut (
        .clk        (clk),
        .rst        (rst),
        .ftw        (ftw),
        .ftw_load   (ftw_load),
        .enable     (enable),
        .sync       (sync),
        .wave_sel   (wave_sel),
        .amp        (amp),
        .rom_addr   (rom_addr),
        .rom_q      (rom_q),
        .dac_value  (dac_value),
        .dac_valid  (dac_valid),
        .phase_wrap (phase_wrap)
    );

    always #10 clk = ~clk;

    // Stub ROM: registered, echoes the top 8 phase bits.
    always @(posedge clk) rom_q <= rom_addr[10:3];

    typedef struct packed {
        logic [7:0] p;
        logic [1:0] sel;
    } sb_t;

    typedef struct {
        logic [1:0] sel;
        logic [7:0] amp;
        logic [7:0] p;
        logic [7:0] exp;
    } vec_t;

    sb_t         sb_q[$];
    logic [31:0] acc_m;
    logic [31:0] ftw_m;
    logic        wrap_m;
    int          vcnt;
    int          n_cmp = 0;
    int          n_bad = 0;

    function automatic logic [7:0] model_dac(logic [7:0] p, logic [1:0] sel, logic [7:0] a);
        int w;
        int m;
        int ai;
        int pi;
        pi = int'(p);
        ai = int'(a);
        case (sel)
            2'd0: w = pi;  // stub ROM returns the phase itself
            2'd1: w = (pi < 128) ? 255 : 0;
            2'd2: w = (pi < 128) ? 2 * pi : 2 * (255 - pi);
            default: w = pi;
        endcase
        m = (w - 128) * ai;
        return 8'(128 + (m >>> 8));
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock: advance the model on the rising edge, compare on the falling edge.
    task automatic step();
        logic [32:0] sum;
        sb_t         e;
        @(posedge clk);
        if (rst) begin
            acc_m  = '0;
            ftw_m  = '0;
            wrap_m = 1'b0;
            vcnt   = 0;
            sb_q.delete();
        end else begin
            sb_q.push_back('{p: acc_m[31:24], sel: wave_sel});
            sum = {1'b0, acc_m} + {1'b0, ftw_m};
            if (sync) begin
                acc_m  = '0;
                wrap_m = 1'b0;
            end else if (enable) begin
                acc_m  = sum[31:0];
                wrap_m = sum[32];
            end else begin
                wrap_m = 1'b0;
            end
            if (ftw_load) ftw_m = ftw;
            if (vcnt < 3) vcnt++;
        end
        @(negedge clk);
        check("rom_addr", 32'(rom_addr), 32'(acc_m[31:21]));
        check("phase_wrap", 32'(phase_wrap), 32'(wrap_m));
        check("dac_valid", 32'(dac_valid), 32'(vcnt == 3));
        if (sb_q.size() == 3) begin
            e = sb_q.pop_front();
            check("sb_dac", 32'(dac_value), 32'(model_dac(e.p, e.sel, amp)));
        end
    endtask

    initial begin
        vec_t vecs[17];
        int   n_wraps;
        int   guard;

        vecs[0]  = '{2'd3, 8'd255, 8'd0,   8'd0};
        vecs[1]  = '{2'd3, 8'd255, 8'd1,   8'd1};
        vecs[2]  = '{2'd3, 8'd255, 8'd128, 8'd128};
        vecs[3]  = '{2'd3, 8'd255, 8'd255, 8'd254};
        vecs[4]  = '{2'd2, 8'd128, 8'd0,   8'd64};
        vecs[5]  = '{2'd2, 8'd128, 8'd127, 8'd191};
        vecs[6]  = '{2'd2, 8'd128, 8'd128, 8'd191};
        vecs[7]  = '{2'd2, 8'd128, 8'd255, 8'd64};
        vecs[8]  = '{2'd2, 8'd255, 8'd200, 8'd110};
        vecs[9]  = '{2'd1, 8'd255, 8'd10,  8'd254};
        vecs[10] = '{2'd1, 8'd255, 8'd200, 8'd0};
        vecs[11] = '{2'd1, 8'd100, 8'd0,   8'd177};
        vecs[12] = '{2'd1, 8'd100, 8'd128, 8'd78};
        vecs[13] = '{2'd0, 8'd255, 8'd77,  8'd77};
        vecs[14] = '{2'd3, 8'd0,   8'd99,  8'd128};
        vecs[15] = '{2'd3, 8'd1,   8'd0,   8'd127};
        vecs[16] = '{2'd3, 8'd1,   8'd255, 8'd128};

        rst = 1'b1; ftw = '0; ftw_load = 1'b0; enable = 1'b0; sync = 1'b0;
        wave_sel = 2'd0; amp = 8'd0;
        acc_m = '0; ftw_m = '0; wrap_m = 1'b0; vcnt = 0;

        step();
        step();
        check("reset_dac", 32'(dac_value), 32'd128);
        $display("reset: dac=%0d valid=%0b wrap=%0b", dac_value, dac_valid, phase_wrap);

        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            check("idle_dac", 32'(dac_value), 32'd128);
            check("idle_wrap", 32'(phase_wrap), 32'd0);
        end
        $display("idle: dac=%0d valid=%0b", dac_value, dac_valid);

        // Sawtooth ramp, full scale.
        wave_sel = 2'd3; amp = 8'd255; ftw = 32'h0100_0000; ftw_load = 1'b1;
        step();
        ftw_load = 1'b0; enable = 1'b1;
        n_wraps = 0;
        for (int i = 0; i < 600; i++) begin
            step();
            if (phase_wrap) n_wraps++;
        end
        check("wrap_count", 32'(n_wraps), 32'd2);
        $display("saw ramp: 600 cycles, wraps=%0d", n_wraps);

        // Triangle at half amplitude.
        wave_sel = 2'd2; amp = 8'd128; sync = 1'b1;
        step();
        sync = 1'b0;
        for (int i = 0; i < 300; i++) step();
        $display("triangle: 300 cycles, n_cmp=%0d", n_cmp);

        // Sine through the stub ROM must equal sawtooth at the same phase.
        wave_sel = 2'd0; amp = 8'd255;
        for (int i = 0; i < 300; i++) step();
        $display("sine stub: 300 cycles, n_cmp=%0d", n_cmp);

        // Load + sync + enable together: sync wins, new step applies afterwards.
        ftw = 32'h0200_0000; ftw_load = 1'b1; sync = 1'b1;
        step();
        check("sync_addr", 32'(rom_addr), 32'd0);
        check("sync_wrap", 32'(phase_wrap), 32'd0);
        ftw_load = 1'b0; sync = 1'b0;
        step();
        check("step1_addr", 32'(rom_addr), 32'd16);
        step();
        check("step2_addr", 32'(rom_addr), 32'd32);
        ftw = 32'h0300_0000; ftw_load = 1'b1;
        step();
        check("old_ftw_addr", 32'(rom_addr), 32'd48);
        ftw_load = 1'b0;
        step();
        check("new_ftw_addr", 32'(rom_addr), 32'd72);
        $display("sync/load: rom_addr=%0d", rom_addr);

        // Reset in the middle of a ramp at half phase.
        ftw = 32'h0100_0000; ftw_load = 1'b1; sync = 1'b1; wave_sel = 2'd3;
        step();
        ftw_load = 1'b0; sync = 1'b0;
        guard = 0;
        while (acc_m != 32'h8000_0000 && guard < 1000) begin
            step();
            guard++;
        end
        check("reach_half_timeout", 32'(guard < 1000), 32'd1);
        rst = 1'b1;
        step();
        check("midrst_dac", 32'(dac_value), 32'd128);
        check("midrst_addr", 32'(rom_addr), 32'd0);
        check("midrst_valid", 32'(dac_valid), 32'd0);
        check("midrst_wrap", 32'(phase_wrap), 32'd0);
        rst = 1'b0;
        step();
        check("post_rst_valid1", 32'(dac_valid), 32'd0);
        check("post_rst_dac", 32'(dac_value), 32'd128);
        step();
        check("post_rst_valid2", 32'(dac_valid), 32'd0);
        step();
        check("post_rst_valid3", 32'(dac_valid), 32'd1);
        check("post_rst_hold_addr", 32'(rom_addr), 32'd0);
        $display("mid reset: valid=%0b dac=%0d", dac_valid, dac_value);

        // Table: park the accumulator at one phase and read the settled output.
        enable = 1'b0;
        foreach (vecs[i]) begin
            wave_sel = vecs[i].sel; amp = vecs[i].amp;
            ftw = {vecs[i].p, 24'd0}; ftw_load = 1'b1; sync = 1'b1; enable = 1'b0;
            step();
            ftw_load = 1'b0; sync = 1'b0; enable = 1'b1;
            step();
            enable = 1'b0;
            for (int k = 0; k < 4; k++) step();
            check("vec_dac", 32'(dac_value), 32'(vecs[i].exp));
            $display("vec %0d: sel=%0d amp=%0d p=%0d dac=%0d want=%0d",
                     i, vecs[i].sel, vecs[i].amp, vecs[i].p, dac_value, vecs[i].exp);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
